// File: rtl/sdp_pipe.sv
// sdp_pipe: simple dual-port RAM (one write port, one read port) with a
// parametrised read pipeline and a first-word-fall-through output buffer.
// Full read throughput is sustained under downstream backpressure. The read
// address ready is credit based and is a function of registers only.
//
// Ports:
//   clk                   clock, all logic on the rising edge
//   rst                   synchronous active-high reset
//   i_wr_addr_data_valid  write request valid
//   o_wr_addr_data_ready  write request ready (always 1)
//   i_wr_addr_data        packed {data, addr}, addr in the LSBs
//   i_rd_addr_valid       read address valid
//   o_rd_addr_ready       read address ready (credit available)
//   i_rd_addr             read address
//   o_rd_data_valid       read response valid (buffer non-empty)
//   i_rd_data_ready       read response ready
//   o_rd_data             read response data, in request order
//
// Build option: define SDP_PIPE_WR_BYPASS_EN for write-first behaviour when a
// read and a write to the same address are accepted at the same edge;
// otherwise the read returns the old RAM contents (read-first).
module sdp_pipe #(
  parameter int unsigned W_DATA = 16,
  parameter int unsigned W_ADDR = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_addr_data_valid,
  output logic                     o_wr_addr_data_ready,
  input  logic [W_DATA+W_ADDR-1:0] i_wr_addr_data,
  input  logic                     i_rd_addr_valid,
  output logic                     o_rd_addr_ready,
  input  logic [W_ADDR-1:0]        i_rd_addr,
  output logic                     o_rd_data_valid,
  input  logic                     i_rd_data_ready,
  output logic [W_DATA-1:0]        o_rd_data
);

  localparam int unsigned CAP = RD_LAT + 1;
  localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW  = $clog2(CAP);
  localparam int unsigned CW  = $clog2(CAP + 1);
  localparam logic [W_ADDR:0] DEPTH_X = (W_ADDR + 1)'(DEPTH);

  logic [W_ADDR-1:0] w_wr_addr;
  logic [W_DATA-1:0] w_wr_data;
  logic              w_wr_en;
  logic              w_rd_in_range;
  logic              w_rd_acc;
  logic              w_pop;
  logic [W_DATA-1:0] w_rd_word;
  logic              w_push_vld;
  logic [W_DATA-1:0] w_push_dat;

  logic [W_DATA-1:0] r_mem [DEPTH];
  logic [W_DATA-1:0] r_fifo [CAP];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_fcnt;
  logic [CW-1:0]     r_used;

  assign w_wr_addr     = i_wr_addr_data[W_ADDR-1:0];
  assign w_wr_data     = i_wr_addr_data[W_ADDR +: W_DATA];
  assign w_wr_en       = i_wr_addr_data_valid && ({1'b0, w_wr_addr} < DEPTH_X);
  assign w_rd_in_range = {1'b0, i_rd_addr} < DEPTH_X;
  assign w_rd_acc      = i_rd_addr_valid && o_rd_addr_ready;
  assign w_pop         = o_rd_data_valid && i_rd_data_ready;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr[IW-1:0]] <= w_wr_data;
  end

  // Snapshot of the addressed word at the accept edge; out-of-range reads
  // return zero.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_range) w_rd_word = r_mem[i_rd_addr[IW-1:0]];
`ifdef SDP_PIPE_WR_BYPASS_EN
    if (w_wr_en && (w_wr_addr == i_rd_addr)) w_rd_word = w_wr_data;
`endif
  end

  // The output buffer entry acts as the final latency register, so only
  // RD_LAT-1 stages sit between the accept edge and the buffer write.
  if (RD_LAT == 1) begin : g_direct
    assign w_push_vld = w_rd_acc;
    assign w_push_dat = w_rd_word;
  end else begin : g_pipe
    logic              r_vld [RD_LAT-1];
    logic [W_DATA-1:0] r_dat [RD_LAT-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned k = 0; k < RD_LAT - 1; k++) r_vld[k] <= 1'b0;
      end else begin
        r_vld[0] <= w_rd_acc;
        for (int unsigned k = 1; k < RD_LAT - 1; k++) r_vld[k] <= r_vld[k-1];
      end
    end

    always_ff @(posedge clk) begin
      r_dat[0] <= w_rd_word;
      for (int unsigned k = 1; k < RD_LAT - 1; k++) r_dat[k] <= r_dat[k-1];
    end

    assign w_push_vld = r_vld[RD_LAT-2];
    assign w_push_dat = r_dat[RD_LAT-2];
  end

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(CAP - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (w_push_vld) r_fifo[r_wptr] <= w_push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
      r_used <= '0;
    end else begin
      if (w_push_vld) r_wptr <= f_inc(r_wptr);
      if (w_pop)      r_rptr <= f_inc(r_rptr);
      r_fcnt <= r_fcnt + CW'(w_push_vld) - CW'(w_pop);
      // Credits cover both in-flight reads and buffered responses.
      r_used <= r_used + CW'(w_rd_acc) - CW'(w_pop);
    end
  end

  assign o_wr_addr_data_ready = 1'b1;
  assign o_rd_addr_ready      = r_used < CW'(CAP);
  assign o_rd_data_valid      = r_fcnt != '0;
  assign o_rd_data            = o_rd_data_valid ? r_fifo[r_rptr] : '0;

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    r_used <= CW'(CAP));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push_vld && !w_pop && (r_fcnt == CW'(CAP))));

endmodule

// File: tb/tb_sdp_pipe.sv
module tb_sdp_pipe;
  localparam int unsigned DEP = 1024;
  localparam int unsigned LAT = 2;
  localparam int unsigned CAP = LAT + 1;
  localparam bit BYPASS =
`ifdef SDP_PIPE_WR_BYPASS_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        wv, wr_rdy, rv, ra_rdy, dv, dr;
  logic [31:0] wad;
  logic [15:0] ra, dd;

  logic        s_wv, s_wrdy, s_rv, s_ardy, s_dv, s_dr;
  logic [21:0] s_wad;
  logic [5:0]  s_ra;
  logic [15:0] s_dd;

  sdp_pipe #(.W_DATA(16), .W_ADDR(16), .DEPTH(1024), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .i_wr_addr_data_valid(wv), .o_wr_addr_data_ready(wr_rdy), .i_wr_addr_data(wad),
    .i_rd_addr_valid(rv), .o_rd_addr_ready(ra_rdy), .i_rd_addr(ra),
    .o_rd_data_valid(dv), .i_rd_data_ready(dr), .o_rd_data(dd)
  );

  sdp_pipe #(.W_DATA(16), .W_ADDR(6), .DEPTH(48), .RD_LAT(2)) dut48 (
    .clk(clk), .rst(rst),
    .i_wr_addr_data_valid(s_wv), .o_wr_addr_data_ready(s_wrdy), .i_wr_addr_data(s_wad),
    .i_rd_addr_valid(s_rv), .o_rd_addr_ready(s_ardy), .i_rd_addr(s_ra),
    .o_rd_data_valid(s_dv), .i_rd_data_ready(s_dr), .o_rd_data(s_dd)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: word array, queue of expected responses in request order.
  logic [15:0] mdl [DEP];
  logic [15:0] exp_q[$];
  logic [15:0] resp_q[$];
  int          resp_cyc[$];
  int          cyc = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_d = '0;

  always @(negedge clk) begin
    logic [15:0] e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("credit_ready", 32'(ra_rdy), 32'(exp_q.size() < CAP));
      if (exp_q.size() == 0) chk("no_stale_valid", 32'(dv), 32'd0);
      if (prev_stall) begin
        chk("stall_valid", 32'(dv), 32'd1);
        chk("stall_data", 32'(dd), 32'(prev_d));
      end
      if (dv && dr) begin
        if (exp_q.size() > 0) chk("resp_data", 32'(dd), 32'(exp_q.pop_front()));
        resp_q.push_back(dd);
        resp_cyc.push_back(cyc);
      end
      if (rv && ra_rdy) begin
        if (ra >= DEP) e = '0;
        else if (BYPASS && wv && (wad[15:0] == ra)) e = wad[31:16];
        else e = mdl[ra[9:0]];
        exp_q.push_back(e);
      end
      if (wv && (wad[15:0] < DEP)) mdl[wad[9:0]] = wad[31:16];
      prev_stall = dv && !dr;
      prev_d = dd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_one(input logic [15:0] a, input logic [15:0] e, input string nm);
    int n;
    int lat;
    ra = a;
    rv = 1'b1;
    n = 0;
    while (!ra_rdy && n < 20) begin
      step();
      n++;
    end
    step();
    rv = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dv && lat < 20);
    chk({nm, "_latency"}, 32'(lat), 32'(LAT));
    chk({nm, "_data"}, 32'(dd), 32'(e));
    @(negedge clk);
    chk({nm, "_one_cycle"}, 32'(dv), 32'd0);
    step();
  endtask

  task automatic rd48(input logic [5:0] a, input logic [15:0] e);
    s_ra = a;
    s_rv = 1'b1;
    chk("t6_ready", 32'(s_ardy), 32'd1);
    step();
    s_rv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("t6_valid%0d", a), 32'(s_dv), 32'd1);
    chk($sformatf("t6_data%0d", a), 32'(s_dd), 32'(e));
    step();
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[11];

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int guard;
    logic [15:0] a;
    rst = 1'b1; wv = 1'b0; wad = '0; rv = 1'b0; ra = '0; dr = 1'b1;
    s_wv = 1'b0; s_wad = '0; s_rv = 1'b0; s_ra = '0; s_dr = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", 32'(dv), 32'd0);
    chk("reset_data", 32'(dd), 32'd0);
    chk("reset_rd_ready", 32'(ra_rdy), 32'd1);
    chk("reset_wr_ready", 32'(wr_rdy), 32'd1);
    step();

    // preload every word so the model never holds unknowns
    for (int i = 0; i < int'(DEP); i++) begin
      wv = 1'b1;
      wad = {16'(i * 7 + 3), 16'(i)};
      s_wv = (i < 48);
      s_wad = {16'(16'h3000 + i), 6'(i)};
      step();
    end
    wv = 1'b0;
    s_wv = 1'b0;

    // basic write then read with latency check
    wv = 1'b1; wad = {16'hABCD, 16'd5}; step(); wv = 1'b0;
    read_one(16'd5, 16'hABCD, "t1");

    // table: back-to-back reads, including range boundaries
    for (int i = 0; i < 8; i++) vt[i] = '{16'(i), 16'(16'h100 + i), 16'(16'h100 + i)};
    vt[8]  = '{16'd1023,  16'hBEEF, 16'hBEEF};
    vt[9]  = '{16'd1024,  16'hDEAD, 16'h0000};
    vt[10] = '{16'hFFFF,  16'h1234, 16'h0000};
    for (int i = 0; i < 11; i++) begin
      wv = 1'b1; wad = {vt[i].wdata, vt[i].addr}; step();
    end
    wv = 1'b0;
    resp_q.delete(); resp_cyc.delete();
    rv = 1'b1;
    for (int i = 0; i < 11; i++) begin
      ra = vt[i].addr;
      chk($sformatf("t2_rd_ready%0d", i), 32'(ra_rdy), 32'd1);
      step();
    end
    rv = 1'b0;
    repeat (4) step();
    chk("t2_resp_count", 32'(resp_q.size()), 32'd11);
    for (int i = 0; i < 11 && i < resp_q.size(); i++) begin
      chk($sformatf("t2_data%0d", i), 32'(resp_q[i]), 32'(vt[i].exp));
      if (i > 0) chk($sformatf("t2_gap%0d", i), 32'(resp_cyc[i] - resp_cyc[i-1]), 32'd1);
    end

    // backpressure: credits stop acceptance at the buffer capacity
    wv = 1'b1; wad = {16'h0108, 16'd8}; step();
    wad = {16'h0109, 16'd9}; step(); wv = 1'b0;
    resp_q.delete();
    dr = 1'b0; rv = 1'b1; k = 0;
    repeat (8) begin
      ra = 16'(k);
      if (ra_rdy) k++;
      step();
    end
    chk("t3_accepts", 32'(k), 32'(CAP));
    chk("t3_ready_low", 32'(ra_rdy), 32'd0);
    dr = 1'b1; guard = 0;
    while (k < 10 && guard < 50) begin
      ra = 16'(k);
      if (ra_rdy) k++;
      step();
      guard++;
    end
    rv = 1'b0;
    repeat (6) step();
    chk("t3_resp_count", 32'(resp_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < resp_q.size(); i++)
      chk($sformatf("t3_data%0d", i), 32'(resp_q[i]), 32'(16'h100 + i));

    // same-edge read/write collision
    wv = 1'b1; wad = {16'h2222, 16'd3}; step();
    wad = {16'h1111, 16'd3}; ra = 16'd3; rv = 1'b1;
    chk("t4_ready", 32'(ra_rdy), 32'd1);
    step();
    wv = 1'b0; rv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_valid", 32'(dv), 32'd1);
    chk("t4_data", 32'(dd), BYPASS ? 32'h1111 : 32'h2222);
    step();
    read_one(16'd3, 16'h1111, "t4_after");

    // reset with reads in flight
    wv = 1'b1; wad = {16'h7777, 16'd20}; step(); wv = 1'b0;
    dr = 1'b0; rv = 1'b1;
    ra = 16'd5; step();
    ra = 16'd6; step();
    rv = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_valid", 32'(dv), 32'd0);
    chk("t5_ready", 32'(ra_rdy), 32'd1);
    dr = 1'b1;
    step();
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_stale", 32'(dv), 32'd0);
      step();
    end
    read_one(16'd20, 16'h7777, "t5_post");

    // small instance: out-of-range write dropped, contents intact
    s_wv = 1'b1; s_wad = {16'h5A5A, 6'd60}; step(); s_wv = 1'b0;
    rd48(6'd60, 16'h0000);
    for (int i = 0; i < 48; i++) rd48(6'(i), 16'(16'h3000 + i));

    // randomized traffic against the model
    repeat (3000) begin
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1024, 65535))
                                      : 16'($urandom_range(0, 1023));
      wv = 1'($urandom_range(0, 1));
      wad = {16'($urandom), a};
      rv = ($urandom_range(0, 2) != 0);
      ra = ($urandom_range(0, 3) == 0) ? a : 16'($urandom_range(0, 1100));
      dr = ($urandom_range(0, 3) != 0);
      step();
    end
    wv = 1'b0; rv = 1'b0; dr = 1'b1;
    repeat (8) step();
    @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
